tl_mem_slave: RTL and testbench
===============================

Name: tl_mem_slave

Overview:
TileLink-UL single-beat responder (slave) backed by an internal register-file memory. It accepts Get, PutFullData and PutPartialData on channel A and returns AccessAckData or AccessAck on channel D. It is the memory-side counterpart for tl_l1_adapter-class masters and serves as a bus endpoint and verification target in the TileLink subsystem. It handles one outstanding transaction at a time.

Parameters:
MEM_WORDS, 256, number of TL_DATA_BYTES-wide words; power of two, at least 2.
BASE_ADDR, 0, byte base address of the memory window; aligned to MEM_WORDS*TL_DATA_BYTES.
RESP_LATENCY, 1, extra wait cycles between A acceptance and d_valid; range 0..15.
SINK_ID, 0, constant driven on d_sink; width TL_SINK_BITS.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  channel A request valid
a_ready  out  1  channel A ready
a_opcode  in  3  TL_A_GET / TL_A_PUTFULL / TL_A_PUTPARTIAL
a_param  in  3  ignored
a_size  in  TL_SIZE_BITS  log2 of transfer bytes
a_source  in  TL_SOURCE_BITS  requester ID
a_address  in  TL_ADDR_BITS  byte address
a_mask  in  TL_DATA_BYTES  byte-lane write enables
a_data  in  TL_DATA_BYTES*8  write data
d_valid  out  1  channel D response valid
d_ready  in  1  channel D ready
d_opcode  out  4  TL_D_ACCESSACK / TL_D_ACCESSACKDATA
d_param  out  2  always 0
d_size  out  TL_SIZE_BITS  echo of a_size
d_source  out  TL_SOURCE_BITS  echo of a_source
d_sink  out  TL_SINK_BITS  SINK_ID
d_denied  out  1  request rejected
d_data  out  TL_DATA_BYTES*8  read data; 0 for AccessAck or denied

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- States: S_IDLE, S_WAIT, S_RESP.
- Reset: state S_IDLE. All response registers clear: d_valid=0, d_opcode=0, d_size=0, d_source=0, d_denied=0, d_data=0. d_param=0 and d_sink=SINK_ID at all times. Memory contents are not reset and are undefined until written.
- a_ready = (state==S_IDLE). It is combinational from state only and never depends on a_valid.
- A fire (a_valid && a_ready), all on the same edge:
  - Latch size, source and opcode class.
  - Evaluate deny.
  - For Put, write the byte lanes whose a_mask bit is set, only when not denied.
  - For Get, capture mem[idx] into the d_data register; capture 0 if denied.
  - Next state is S_WAIT if RESP_LATENCY>0, else S_RESP.
- Word index: idx = a_address[log2(TL_DATA_BYTES) +: log2(MEM_WORDS)].
- S_WAIT: a 4-bit counter loads RESP_LATENCY-1 on the A fire and decrements each cycle. When it reaches 0, go to S_RESP.
- S_RESP:
  - d_valid=1. All d_* fields hold stable until d_ready.
  - d_opcode is TL_D_ACCESSACKDATA for Get and TL_D_ACCESSACK for Put.
  - On d_valid && d_ready, go to S_IDLE and clear d_valid.
- Back-to-back: the next A is accepted no earlier than the cycle after the D handshake. Minimum A-to-A spacing is RESP_LATENCY+2 cycles.
- Unsupported a_opcode (anything other than Get/PutFull/PutPartial):
  - Accepted and answered with AccessAck, d_denied=1.
  - No memory write.
- Read-after-write: a Get following a Put to the same word returns the new data.
- Reset mid-transaction returns to S_IDLE immediately. Any pending response is dropped. A write that completed at an earlier edge is retained.

Optional Feature:
TL_SLAVE_DENY_CHECK_EN
- Defined: d_denied=1 and no memory write when any of these holds:
  - address is outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*TL_DATA_BYTES)
  - a_size > log2(TL_DATA_BYTES)
  - address is not aligned to 2^a_size
  A denied Get returns d_data=0.
- Undefined: these checks are omitted, so d_denied is 1 only for unsupported opcodes. The address wraps modulo the window using idx. The response is otherwise unchanged.

Test Plan:
- PutFull addr 0x10, data 0xDEADBEEF, mask all-1, source 3 -> after RESP_LATENCY+1 cycles: d_valid=1, d_opcode=TL_D_ACCESSACK, d_source=3, d_denied=0.
- Get addr 0x10 after the previous test -> AccessAckData, d_data=0xDEADBEEF, d_size echoes a_size.
- PutPartial addr 0x10, data 0x11223344, mask 4'b0101 -> a following Get returns 0xDE22BE44 (lanes 0 and 2 updated).
- Hold d_ready=0 for 5 cycles in S_RESP -> d_valid and all d_* fields stable, a_ready=0. Release -> a_ready=1 on the next cycle.
- With TL_SLAVE_DENY_CHECK_EN: Get at BASE_ADDR + MEM_WORDS*TL_DATA_BYTES -> d_denied=1, d_data=0. Put to the same address -> d_denied=1 and memory unchanged.
- Assert rst_n=0 during S_WAIT -> d_valid=0 and a_ready=1 after release. Unsupported a_opcode=3 -> AccessAck with d_denied=1.

Source files
------------

// File: rtl/tl_mem_slave_if.sv
// tl_mem_slave_if: TileLink-UL channel A/D signal bundle with master and slave views.
interface tl_if #(
    parameter int TL_ADDR_BITS   = 32,
    parameter int TL_DATA_BYTES  = 4,
    parameter int TL_SIZE_BITS   = 3,
    parameter int TL_SOURCE_BITS = 8,
    parameter int TL_SINK_BITS   = 2
) ();
    logic                        a_valid;
    logic                        a_ready;
    logic [2:0]                  a_opcode;
    logic [2:0]                  a_param;
    logic [TL_SIZE_BITS-1:0]     a_size;
    logic [TL_SOURCE_BITS-1:0]   a_source;
    logic [TL_ADDR_BITS-1:0]     a_address;
    logic [TL_DATA_BYTES-1:0]    a_mask;
    logic [TL_DATA_BYTES*8-1:0]  a_data;
    logic                        d_valid;
    logic                        d_ready;
    logic [3:0]                  d_opcode;
    logic [1:0]                  d_param;
    logic [TL_SIZE_BITS-1:0]     d_size;
    logic [TL_SOURCE_BITS-1:0]   d_source;
    logic [TL_SINK_BITS-1:0]     d_sink;
    logic                        d_denied;
    logic [TL_DATA_BYTES*8-1:0]  d_data;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
    );
endinterface

// File: rtl/tl_mem_slave.sv
// tl_mem_slave: TileLink-UL single-beat memory responder, one transaction in flight.
// Define TL_SLAVE_DENY_CHECK_EN to deny out-of-window, oversized and misaligned requests.
module tl_mem_slave #(
    parameter int                         TL_ADDR_BITS   = 32,
    parameter int                         TL_DATA_BYTES  = 4,
    parameter int                         TL_SIZE_BITS   = 3,
    parameter int                         TL_SOURCE_BITS = 8,
    parameter int                         TL_SINK_BITS   = 2,
    parameter int                         MEM_WORDS      = 256,
    parameter logic [TL_ADDR_BITS-1:0]    BASE_ADDR      = '0,
    parameter int                         RESP_LATENCY   = 1,
    parameter logic [TL_SINK_BITS-1:0]    SINK_ID        = '0
) (
    input  logic clk,
    input  logic rst_n,
    tl_if.slave  tl
);
    localparam logic [2:0] TL_A_PUTFULL       = 3'd0;
    localparam logic [2:0] TL_A_PUTPARTIAL    = 3'd1;
    localparam logic [2:0] TL_A_GET           = 3'd4;
    localparam logic [3:0] TL_D_ACCESSACK     = 4'd0;
    localparam logic [3:0] TL_D_ACCESSACKDATA = 4'd1;
    localparam int         OFF = $clog2(TL_DATA_BYTES);
    localparam int         IW  = $clog2(MEM_WORDS);
    localparam int         DW  = TL_DATA_BYTES * 8;
    localparam logic [3:0] CNT_INIT = RESP_LATENCY > 0 ? 4'(RESP_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                    r_state, w_state_nx;
    logic [3:0]                r_cnt;
    logic [DW-1:0]             r_mem [MEM_WORDS];
    logic [3:0]                r_d_opcode;
    logic [TL_SIZE_BITS-1:0]   r_d_size;
    logic [TL_SOURCE_BITS-1:0] r_d_source;
    logic                      r_d_denied;
    logic [DW-1:0]             r_d_data;
    logic                      w_fire, w_get, w_put, w_deny;
    logic [IW-1:0]             w_idx;
    logic                      w_unused;

    assign w_fire = tl.a_valid && tl.a_ready;
    assign w_get  = tl.a_opcode == TL_A_GET;
    assign w_put  = tl.a_opcode == TL_A_PUTFULL || tl.a_opcode == TL_A_PUTPARTIAL;
    assign w_idx  = tl.a_address[OFF +: IW];

`ifdef TL_SLAVE_DENY_CHECK_EN
    logic [TL_ADDR_BITS-1:0] w_align;
    assign w_align = ~({TL_ADDR_BITS{1'b1}} << tl.a_size);
    // BASE_ADDR is window-aligned, so in-window means the bits above the index match
    assign w_deny  = !(w_get || w_put)
                  || tl.a_address[TL_ADDR_BITS-1:OFF+IW] != BASE_ADDR[TL_ADDR_BITS-1:OFF+IW]
                  || tl.a_size > TL_SIZE_BITS'(OFF)
                  || |(tl.a_address & w_align);
`else
    assign w_deny  = !(w_get || w_put);
`endif

    assign w_unused = &{1'b0, tl.a_param, tl.a_size, tl.a_address};

    assign tl.a_ready  = r_state == S_IDLE;
    assign tl.d_valid  = r_state == S_RESP;
    assign tl.d_opcode = r_d_opcode;
    assign tl.d_param  = '0;
    assign tl.d_size   = r_d_size;
    assign tl.d_source = r_d_source;
    assign tl.d_sink   = SINK_ID;
    assign tl.d_denied = r_d_denied;
    assign tl.d_data   = r_d_data;

    always_ff @(posedge clk) begin
        if (w_fire && w_put && !w_deny)
            for (int b = 0; b < TL_DATA_BYTES; b++)
                if (tl.a_mask[b]) r_mem[w_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nx = w_fire ? (RESP_LATENCY > 0 ? S_WAIT : S_RESP) : S_IDLE;
            S_WAIT:  w_state_nx = r_cnt == 4'd0 ? S_RESP : S_WAIT;
            S_RESP:  w_state_nx = tl.d_ready ? S_IDLE : S_RESP;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Response fields only change on acceptance, so they hold while D is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_denied <= 1'b0;
            r_d_data   <= '0;
        end else if (w_fire) begin
            r_cnt      <= CNT_INIT;
            r_d_opcode <= w_get ? TL_D_ACCESSACKDATA : TL_D_ACCESSACK;
            r_d_size   <= tl.a_size;
            r_d_source <= tl.a_source;
            r_d_denied <= w_deny;
            r_d_data   <= w_get && !w_deny ? r_mem[w_idx] : '0;
        end else if (r_state == S_WAIT) begin
            r_cnt      <= r_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_tl_mem_slave.sv
// tb_tl_mem_slave: table vectors, corner sequences and random traffic against a byte-level memory model.
module tb_tl_mem_slave;
    localparam int          LAT  = 2;
    localparam int          MW   = 256;
    localparam int          DB   = 4;
    localparam logic [1:0]  SID  = 2'd2;
    localparam logic [31:0] BASE = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tl_if tl ();

    tl_mem_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .RESP_LATENCY(LAT), .SINK_ID(SID)) dut (
        .clk(clk), .rst_n(rst_n), .tl(tl.slave)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  src;
        logic [3:0]  mask;
        logic [31:0] data;
        int          hold;
        logic [3:0]  eop;
        bit          eden;
        logic [31:0] edata;
    } vec_t;

    logic [7:0] mb [MW*DB];
    bit         kb [MW*DB];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_deny(input logic [2:0] op, input logic [31:0] a, input logic [2:0] sz);
        bit d;
        d = !(op == 3'd0 || op == 3'd1 || op == 3'd4);
`ifdef TL_SLAVE_DENY_CHECK_EN
        if (64'(a) < 64'(BASE) || 64'(a) >= 64'(BASE) + 64'(MW*DB)) d = 1'b1;
        if (sz > 3'd2) d = 1'b1;
        if (a % (32'd1 << sz) != 0) d = 1'b1;
`endif
        return d;
    endfunction

    function automatic int base_byte(input logic [31:0] a);
        return int'(((a - BASE) / DB) % MW) * DB;
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [2:0] sz,
                               input logic [3:0] m, input logic [31:0] d);
        int bb;
        bb = base_byte(a);
        if (!is_deny(op, a, sz) && (op == 3'd0 || op == 3'd1))
            for (int l = 0; l < DB; l++)
                if (m[l]) begin
                    mb[bb+l] = d[8*l +: 8];
                    kb[bb+l] = 1'b1;
                end
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [31:0] a, input logic [2:0] sz,
                           input logic [7:0] src, input logic [3:0] m, input logic [31:0] d);
        tl.a_valid   = 1'b1;
        tl.a_opcode  = op;
        tl.a_param   = 3'($urandom_range(0, 7));
        tl.a_size    = sz;
        tl.a_source  = src;
        tl.a_address = a;
        tl.a_mask    = m;
        tl.a_data    = d;
    endtask

    task automatic txn(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [2:0] sz,
                       input logic [7:0] src, input logic [3:0] m, input logic [31:0] d, input int hold,
                       input logic [3:0] eop, input bit eden, input logic [31:0] edata, input bit cdata);
        int k;
        logic [47:0] snap;
        @(negedge clk);
        chk({tag, "/a_ready_idle"}, 64'(tl.a_ready), 64'd1);
        drive_a(op, a, sz, src, m, d);
        @(posedge clk);
        @(negedge clk);
        tl.a_valid = 1'b0;
        chk({tag, "/a_ready_busy"}, 64'(tl.a_ready), 64'd0);
        k = 1;
        while (!tl.d_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/latency"}, 64'(k), 64'(LAT + 1));
        chk({tag, "/d_opcode"}, 64'(tl.d_opcode), 64'(eop));
        chk({tag, "/d_denied"}, 64'(tl.d_denied), 64'(eden));
        chk({tag, "/d_size"}, 64'(tl.d_size), 64'(sz));
        chk({tag, "/d_source"}, 64'(tl.d_source), 64'(src));
        chk({tag, "/d_sink_param"}, 64'({tl.d_sink, tl.d_param}), 64'({SID, 2'd0}));
        if (cdata) chk({tag, "/d_data"}, 64'(tl.d_data), 64'(edata));
        snap = {tl.d_opcode, tl.d_size, tl.d_source, tl.d_denied, tl.d_data};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid_ready"}, 64'({tl.d_valid, tl.a_ready}), 64'b10);
            chk({tag, "/hold_stable"}, 64'({tl.d_opcode, tl.d_size, tl.d_source, tl.d_denied, tl.d_data}), 64'(snap));
        end
        tl.d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tl.d_ready = 1'b0;
        chk({tag, "/after_d_valid"}, 64'(tl.d_valid), 64'd0);
        chk({tag, "/after_a_ready"}, 64'(tl.a_ready), 64'd1);
    endtask

    task automatic model_txn(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [2:0] sz,
                             input logic [7:0] src, input logic [3:0] m, input logic [31:0] d, input int hold);
        bit den, cd;
        logic [31:0] ed;
        int bb;
        den = is_deny(op, a, sz);
        ed = '0;
        cd = 1'b1;
        bb = base_byte(a);
        if (op == 3'd4 && !den)
            for (int l = 0; l < DB; l++) begin
                ed[8*l +: 8] = mb[bb+l];
                if (!kb[bb+l]) cd = 1'b0;
            end
        txn(tag, op, a, sz, src, m, d, hold, op == 3'd4 ? 4'd1 : 4'd0, den, ed, cd);
        model_apply(op, a, sz, m, d);
    endtask

    task automatic reset_in_wait(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_a(op, a, 3'd2, 8'h42, 4'hF, d);
        @(posedge clk);
        @(negedge clk);
        tl.a_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "/rst_valid_ready"}, 64'({tl.d_valid, tl.a_ready}), 64'b01);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        chk({tag, "/post_rst_valid_ready"}, 64'({tl.d_valid, tl.a_ready}), 64'b01);
        chk({tag, "/post_rst_fields"}, 64'({tl.d_opcode, tl.d_denied, tl.d_data}), 64'd0);
        model_apply(op, a, 3'd2, 4'hF, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[9];
        tv[0] = '{3'd0, 32'h10,  3'd2, 8'h03, 4'hF,   32'hDEADBEEF, 0, 4'd0, 1'b0, 32'h0};
        tv[1] = '{3'd4, 32'h10,  3'd2, 8'h05, 4'hF,   32'h0,        0, 4'd1, 1'b0, 32'hDEADBEEF};
        tv[2] = '{3'd1, 32'h10,  3'd2, 8'h01, 4'b0101, 32'h11223344, 0, 4'd0, 1'b0, 32'h0};
        tv[3] = '{3'd4, 32'h10,  3'd2, 8'h07, 4'hF,   32'h0,        5, 4'd1, 1'b0, 32'hDE22BE44};
        tv[4] = '{3'd3, 32'h10,  3'd2, 8'h09, 4'hF,   32'h0,        1, 4'd0, 1'b1, 32'h0};
        tv[5] = '{3'd4, 32'h10,  3'd2, 8'h0B, 4'hF,   32'h0,        0, 4'd1, 1'b0, 32'hDE22BE44};
        tv[6] = '{3'd0, 32'h3FC, 3'd2, 8'hAA, 4'hF,   32'hCAFEF00D, 2, 4'd0, 1'b0, 32'h0};
        tv[7] = '{3'd4, 32'h3FC, 3'd1, 8'hFF, 4'hF,   32'h0,        0, 4'd1, 1'b0, 32'hCAFEF00D};
        tv[8] = '{3'd1, 32'h12,  3'd1, 8'h0C, 4'b1100, 32'h55660000, 0, 4'd0, 1'b0, 32'h0};

        for (int i = 0; i < MW*DB; i++) kb[i] = 1'b0;
        tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_param = '0; tl.a_size = '0;
        tl.a_source = '0; tl.a_address = '0; tl.a_mask = '0; tl.a_data = '0; tl.d_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset/valid_ready", 64'({tl.d_valid, tl.a_ready}), 64'b01);
        chk("reset/fields", 64'({tl.d_opcode, tl.d_size, tl.d_source, tl.d_denied, tl.d_data}), 64'd0);
        chk("reset/sink_param", 64'({tl.d_sink, tl.d_param}), 64'({SID, 2'd0}));
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset/released_ready", 64'(tl.a_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            txn($sformatf("vec%0d", i), tv[i].op, tv[i].addr, tv[i].size, tv[i].src, tv[i].mask, tv[i].data,
                tv[i].hold, tv[i].eop, tv[i].eden, tv[i].edata, 1'b1);
            model_apply(tv[i].op, tv[i].addr, tv[i].size, tv[i].mask, tv[i].data);
        end
        txn("raw_partial16", 3'd4, 32'h13, 3'd0, 8'h0D, 4'hF, 32'h0, 0, 4'd1, 1'b0, 32'h5566BE44, 1'b1);

        txn("w0_init", 3'd0, 32'h0, 3'd2, 8'h01, 4'hF, 32'hA5A5A5A5, 0, 4'd0, 1'b0, 32'h0, 1'b1);
        model_apply(3'd0, 32'h0, 3'd2, 4'hF, 32'hA5A5A5A5);
`ifdef TL_SLAVE_DENY_CHECK_EN
        txn("oob_get", 3'd4, 32'h400, 3'd2, 8'h02, 4'hF, 32'h0, 1, 4'd1, 1'b1, 32'h0, 1'b1);
        txn("oob_put", 3'd0, 32'h400, 3'd2, 8'h03, 4'hF, 32'h12345678, 0, 4'd0, 1'b1, 32'h0, 1'b1);
        txn("oob_after", 3'd4, 32'h0, 3'd2, 8'h04, 4'hF, 32'h0, 0, 4'd1, 1'b0, 32'hA5A5A5A5, 1'b1);
        txn("misalign_get", 3'd4, 32'h12, 3'd2, 8'h05, 4'hF, 32'h0, 0, 4'd1, 1'b1, 32'h0, 1'b1);
        txn("big_size_get", 3'd4, 32'h10, 3'd3, 8'h06, 4'hF, 32'h0, 0, 4'd1, 1'b1, 32'h0, 1'b1);
`else
        txn("wrap_get", 3'd4, 32'h400, 3'd2, 8'h02, 4'hF, 32'h0, 1, 4'd1, 1'b0, 32'hA5A5A5A5, 1'b1);
        txn("wrap_put", 3'd0, 32'h400, 3'd2, 8'h03, 4'hF, 32'h12345678, 0, 4'd0, 1'b0, 32'h0, 1'b1);
        model_apply(3'd0, 32'h400, 3'd2, 4'hF, 32'h12345678);
        txn("wrap_after", 3'd4, 32'h0, 3'd2, 8'h04, 4'hF, 32'h0, 0, 4'd1, 1'b0, 32'h12345678, 1'b1);
        txn("misalign_get", 3'd4, 32'h12, 3'd2, 8'h05, 4'hF, 32'h0, 0, 4'd1, 1'b0, 32'h5566BE44, 1'b1);
        txn("big_size_get", 3'd4, 32'h10, 3'd3, 8'h06, 4'hF, 32'h0, 0, 4'd1, 1'b0, 32'h5566BE44, 1'b1);
`endif

        reset_in_wait("rst_get", 3'd4, 32'h10, 32'h0);
        reset_in_wait("rst_put", 3'd0, 32'h24, 32'h0BADF00D);
        txn("rst_put_kept", 3'd4, 32'h24, 3'd2, 8'h11, 4'hF, 32'h0, 0, 4'd1, 1'b0, 32'h0BADF00D, 1'b1);
        txn("rst_mem_kept", 3'd4, 32'h3FC, 3'd2, 8'h12, 4'hF, 32'h0, 0, 4'd1, 1'b0, 32'hCAFEF00D, 1'b1);

        for (int n = 0; n < 250; n++) begin
            logic [2:0] op, sz;
            logic [31:0] a;
            int r, r2;
            r = $urandom_range(0, 9);
            op = r < 3 ? 3'd4 : r < 6 ? 3'd0 : r < 8 ? 3'd1 : r == 9 ? 3'd4 : 3'($urandom_range(5, 7));
            if (r == 8 && $urandom_range(0, 1) == 1) op = 3'($urandom_range(2, 3));
            a = 32'($urandom_range(0, 15)) * 4;
            sz = 3'($urandom_range(0, 2));
            r2 = $urandom_range(0, 9);
            if (r2 < 7) a += (32'($urandom_range(0, 3)) >> sz) << sz;
            else if (r2 == 7) a += 32'($urandom_range(0, 3));
            else if (r2 == 8) sz = 3'd3;
            else a += 32'h400 * 32'($urandom_range(1, 3));
            model_txn($sformatf("rnd%0d", n), op, a, sz, 8'($urandom), 4'($urandom), $urandom, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
